// File: rtl/adc_dac_loop_mc.sv
// Multi-channel ADC averaging front end with 16Q48 result registers and
// per-channel saturating DAC code generation (direct request or ADC loopback).
module adc_dac_loop_mc #(
   parameter int FLOAT_WIDTH = 64,
   parameter int FRAC_BITS   = 48,
   parameter int ADC_WIDTH   = 12,
   parameter int DAC_WIDTH   = 14,
   parameter int N_CH        = 2,
   parameter int LOG2_AVG    = 4
) (
   input  logic                        ADC_CLK,
   input  logic                        RST,
   input  logic                        ENABLE,
   input  logic                        START,
   input  logic [N_CH*ADC_WIDTH-1:0]   ADC_DATA_IN,
   input  logic [N_CH*FLOAT_WIDTH-1:0] DAC_VOLT_IN,
   input  logic [N_CH-1:0]             DAC_SRC_SEL,
   output logic                        BUSY,
   output logic                        DONE,
   output logic [N_CH*FLOAT_WIDTH-1:0] ADC_16Q48_OUT,
   output logic [N_CH*DAC_WIDTH-1:0]   DAC_CODE_OUT,
   output logic [N_CH-1:0]             DAC_SAT
);

   localparam int ACC_W = ADC_WIDTH + LOG2_AVG;
   localparam int CNT_W = LOG2_AVG + 1;
   localparam int SHIFT = FRAC_BITS - (ADC_WIDTH - 1) - LOG2_AVG;
   localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);
   localparam logic [DAC_WIDTH-1:0] DAC_MAX  = {1'b0, {(DAC_WIDTH-1){1'b1}}};
   localparam logic [DAC_WIDTH-1:0] DAC_MIN  = {1'b1, {(DAC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                      state_r;
   logic                        busy_r;
   logic                        done_r;
   logic [CNT_W-1:0]            cnt_r;
   logic signed [ACC_W-1:0]     acc_r [N_CH];
   logic [N_CH*FLOAT_WIDTH-1:0] adc_out_r;

   logic                        start_acc_s;
   logic signed [ACC_W-1:0]     samp_ext_s [N_CH];
   logic [FLOAT_WIDTH-1:0]      adc_res_s [N_CH];

   // Start qualification, sample sign extension and mean-to-16Q48 scaling.
   always_comb begin
      start_acc_s = (state_r == ST_IDLE) && START && ENABLE;
      for (int k = 0; k < N_CH; k++) begin
         samp_ext_s[k] = ACC_W'($signed(ADC_DATA_IN[k*ADC_WIDTH +: ADC_WIDTH]));
         adc_res_s[k]  = FLOAT_WIDTH'(acc_r[k]) << SHIFT;
      end
   end

   // Acquisition FSM with accumulators, sample counter and held results.
   always_ff @(posedge ADC_CLK or posedge RST) begin
      if (RST) begin
         state_r   <= ST_IDLE;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cnt_r     <= '0;
         adc_out_r <= '0;
         for (int k = 0; k < N_CH; k++) begin
            acc_r[k] <= '0;
         end
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_acc_s) begin
                  state_r <= ST_ACQ;
                  busy_r  <= 1'b1;
                  cnt_r   <= '0;
                  for (int k = 0; k < N_CH; k++) begin
                     acc_r[k] <= '0;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_ACQ: begin
               // An abort leaves the held results untouched and never pulses DONE.
               if (!ENABLE) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  for (int k = 0; k < N_CH; k++) begin
                     acc_r[k] <= acc_r[k] + samp_ext_s[k];
                  end
                  cnt_r <= cnt_r + CNT_W'(1);
                  if (cnt_r == LAST_CNT) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                  end else begin
                     busy_r <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               for (int k = 0; k < N_CH; k++) begin
                  adc_out_r[k*FLOAT_WIDTH +: FLOAT_WIDTH] <= adc_res_s[k];
               end
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY          = busy_r;
   assign DONE          = done_r;
   assign ADC_16Q48_OUT = adc_out_r;

   for (genvar k = 0; k < N_CH; k++) begin : g_dac
      logic [FLOAT_WIDTH-1:0]           v_s;
      logic [FLOAT_WIDTH-FRAC_BITS-1:0] int_s;
      logic [DAC_WIDTH-1:0]             code_s;
      logic                             sat_s;
      logic [DAC_WIDTH-1:0]             code_r;
      logic                             sat_r;
      logic                             unused_lsb_s;

      // Source select, range test and truncating/saturating code conversion.
      always_comb begin
         if (DAC_SRC_SEL[k]) begin
            v_s = adc_out_r[k*FLOAT_WIDTH +: FLOAT_WIDTH];
         end else begin
            v_s = DAC_VOLT_IN[k*FLOAT_WIDTH +: FLOAT_WIDTH];
         end
         int_s = v_s[FLOAT_WIDTH-1:FRAC_BITS];
         if ((&int_s) || (~|int_s)) begin
            code_s = {v_s[FLOAT_WIDTH-1], v_s[FRAC_BITS-1 -: DAC_WIDTH-1]};
            sat_s  = 1'b0;
         end else if (v_s[FLOAT_WIDTH-1]) begin
            code_s = DAC_MIN;
            sat_s  = 1'b1;
         end else begin
            code_s = DAC_MAX;
            sat_s  = 1'b1;
         end
      end

      assign unused_lsb_s = ^v_s[FRAC_BITS-DAC_WIDTH:0];

      // Code register and sticky flag; a new saturation beats the START clear.
      always_ff @(posedge ADC_CLK or posedge RST) begin
         if (RST) begin
            code_r <= '0;
            sat_r  <= 1'b0;
         end else begin
            code_r <= code_s;
            if (start_acc_s) begin
               sat_r <= sat_s;
            end else begin
               sat_r <= sat_r | sat_s;
            end
         end
      end

      assign DAC_CODE_OUT[k*DAC_WIDTH +: DAC_WIDTH] = code_r;
      assign DAC_SAT[k]                             = sat_r;
   end

endmodule

// File: tb/tb_adc_dac_loop_mc.sv
// Directed self-checking bench for adc_dac_loop_mc at default parameters.
module tb_adc_dac_loop_mc;

   logic          ADC_CLK = 1'b0;
   logic          RST;
   logic          ENABLE;
   logic          START;
   logic [23:0]   ADC_DATA_IN;
   logic [127:0]  DAC_VOLT_IN;
   logic [1:0]    DAC_SRC_SEL;
   logic          BUSY;
   logic          DONE;
   logic [127:0]  ADC_16Q48_OUT;
   logic [27:0]   DAC_CODE_OUT;
   logic [1:0]    DAC_SAT;

   int checks   = 0;
   int failures = 0;

   adc_dac_loop_mc dut (
      .ADC_CLK      (ADC_CLK),
      .RST          (RST),
      .ENABLE       (ENABLE),
      .START        (START),
      .ADC_DATA_IN  (ADC_DATA_IN),
      .DAC_VOLT_IN  (DAC_VOLT_IN),
      .DAC_SRC_SEL  (DAC_SRC_SEL),
      .BUSY         (BUSY),
      .DONE         (DONE),
      .ADC_16Q48_OUT(ADC_16Q48_OUT),
      .DAC_CODE_OUT (DAC_CODE_OUT),
      .DAC_SAT      (DAC_SAT)
   );

   always #5 ADC_CLK = ~ADC_CLK;

   task automatic tick();
      @(posedge ADC_CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; ENABLE = 1'b0; START = 1'b0;
      ADC_DATA_IN = '0; DAC_VOLT_IN = '0; DAC_SRC_SEL = 2'b00;
      repeat (2) tick();
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
      checks++; if (ADC_16Q48_OUT !== 128'h0) begin failures++; $display("FAIL reset_adc got=%h exp=0", ADC_16Q48_OUT); end
      checks++; if (DAC_CODE_OUT !== 28'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", DAC_CODE_OUT); end
      checks++; if (DAC_SAT !== 2'b00) begin failures++; $display("FAIL reset_sat got=%b exp=00", DAC_SAT); end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_avg_const();
      int cyc;
      ADC_DATA_IN = {12'hC00, 12'h400};
      ENABLE = 1'b1; START = 1'b1;
      tick();
      START = 1'b0;
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL const_busy got=%b exp=1", BUSY); end
      cyc = 0;
      while (DONE !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      checks++; if (cyc !== 17) begin failures++; $display("FAIL const_latency got=%0d exp=17", cyc); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL const_busy_done got=%b exp=0", BUSY); end
      checks++; if (ADC_16Q48_OUT[63:0] !== 64'h0000_8000_0000_0000) begin failures++; $display("FAIL const_ch0 got=%h exp=0000800000000000", ADC_16Q48_OUT[63:0]); end
      checks++; if (ADC_16Q48_OUT[127:64] !== 64'hFFFF_8000_0000_0000) begin failures++; $display("FAIL const_ch1 got=%h exp=ffff800000000000", ADC_16Q48_OUT[127:64]); end
      tick();
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL const_done_pulse got=%b exp=0", DONE); end
   endtask

   task automatic test_loopback();
      DAC_SRC_SEL = 2'b11;
      tick();
      checks++; if (DAC_CODE_OUT !== {14'h3000, 14'h1000}) begin failures++; $display("FAIL loop_code got=%h exp=%h", DAC_CODE_OUT, {14'h3000, 14'h1000}); end
      checks++; if (DAC_SAT !== 2'b00) begin failures++; $display("FAIL loop_sat got=%b exp=00", DAC_SAT); end
      DAC_SRC_SEL = 2'b00;
   endtask

   task automatic test_dac_volt();
      DAC_VOLT_IN = {64'h0001_0000_0000_0000, 64'h0000_8000_0000_0000};
      tick();
      checks++; if (DAC_CODE_OUT !== {14'h1FFF, 14'h1000}) begin failures++; $display("FAIL volt_a_code got=%h exp=%h", DAC_CODE_OUT, {14'h1FFF, 14'h1000}); end
      checks++; if (DAC_SAT !== 2'b10) begin failures++; $display("FAIL volt_a_sat got=%b exp=10", DAC_SAT); end
      DAC_VOLT_IN = {64'h0000_0008_0000_0001, 64'hFFFF_0000_0000_0000};
      tick();
      checks++; if (DAC_CODE_OUT !== {14'h0001, 14'h2000}) begin failures++; $display("FAIL volt_b_code got=%h exp=%h", DAC_CODE_OUT, {14'h0001, 14'h2000}); end
      checks++; if (DAC_SAT !== 2'b10) begin failures++; $display("FAIL volt_b_sat got=%b exp=10", DAC_SAT); end
      DAC_VOLT_IN = {64'hFFFF_C000_0000_0000, 64'hFFFE_0000_0000_0000};
      tick();
      checks++; if (DAC_CODE_OUT !== {14'h3800, 14'h2000}) begin failures++; $display("FAIL volt_c_code got=%h exp=%h", DAC_CODE_OUT, {14'h3800, 14'h2000}); end
      checks++; if (DAC_SAT !== 2'b11) begin failures++; $display("FAIL volt_c_sat got=%b exp=11", DAC_SAT); end
   endtask

   task automatic test_start_clear_alt();
      logic [11:0] s0;
      DAC_VOLT_IN = {64'hFFFE_0000_0000_0000, 64'h0};
      START = 1'b1;
      tick();
      START = 1'b0;
      checks++; if (DAC_SAT !== 2'b10) begin failures++; $display("FAIL clear_sat got=%b exp=10", DAC_SAT); end
      DAC_VOLT_IN = '0;
      for (int i = 0; i < 16; i++) begin
         s0 = (i % 2 == 0) ? 12'h7FF : 12'h800;
         ADC_DATA_IN = {12'h001, s0};
         tick();
      end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL alt_done_early got=%b exp=0", DONE); end
      tick();
      checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL alt_done got=%b exp=1", DONE); end
      checks++; if (ADC_16Q48_OUT[63:0] !== 64'hFFFF_FFF0_0000_0000) begin failures++; $display("FAIL alt_ch0 got=%h exp=fffffff000000000", ADC_16Q48_OUT[63:0]); end
      checks++; if (ADC_16Q48_OUT[127:64] !== 64'h0000_0020_0000_0000) begin failures++; $display("FAIL alt_ch1 got=%h exp=0000002000000000", ADC_16Q48_OUT[127:64]); end
      checks++; if (DAC_SAT !== 2'b10) begin failures++; $display("FAIL alt_sat_sticky got=%b exp=10", DAC_SAT); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      ADC_DATA_IN = {12'h001, 12'h200};
      START = 1'b1;
      tick();
      cyc = 0;
      while (DONE !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      checks++; if (cyc !== 17) begin failures++; $display("FAIL b2b_latency1 got=%0d exp=17", cyc); end
      checks++; if (ADC_16Q48_OUT !== {64'h0000_0020_0000_0000, 64'h0000_4000_0000_0000}) begin failures++; $display("FAIL b2b_result1 got=%h", ADC_16Q48_OUT); end
      ADC_DATA_IN = {12'hC00, 12'h400};
      tick();
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b exp=1", BUSY); end
      START = 1'b0;
      cyc = 0;
      while (DONE !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      checks++; if (cyc !== 17) begin failures++; $display("FAIL b2b_latency2 got=%0d exp=17", cyc); end
      checks++; if (ADC_16Q48_OUT !== {64'hFFFF_8000_0000_0000, 64'h0000_8000_0000_0000}) begin failures++; $display("FAIL b2b_result2 got=%h", ADC_16Q48_OUT); end
      checks++; if (DAC_SAT !== 2'b00) begin failures++; $display("FAIL b2b_sat got=%b exp=00", DAC_SAT); end
   endtask

   task automatic test_abort();
      logic seen_done;
      ADC_DATA_IN = {12'h7FF, 12'h7FF};
      START = 1'b1;
      tick();
      for (int i = 1; i <= 7; i++) begin
         START = (i == 3) ? 1'b1 : 1'b0;
         tick();
      end
      START = 1'b0;
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL abort_busy_pre got=%b exp=1", BUSY); end
      ENABLE = 1'b0;
      tick();
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", BUSY); end
      START = 1'b1;
      repeat (2) tick();
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_disabled_start got=%b exp=0", BUSY); end
      START = 1'b0; ENABLE = 1'b1;
      seen_done = 1'b0;
      repeat (25) begin tick(); if (DONE === 1'b1) seen_done = 1'b1; end
      checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
      checks++; if (ADC_16Q48_OUT !== {64'hFFFF_8000_0000_0000, 64'h0000_8000_0000_0000}) begin failures++; $display("FAIL abort_hold got=%h", ADC_16Q48_OUT); end
   endtask

   task automatic test_reset_mid_acq();
      logic seen_done;
      DAC_VOLT_IN = {64'hFFFE_0000_0000_0000, 64'h0000_8000_0000_0000};
      START = 1'b1;
      tick();
      START = 1'b0;
      repeat (5) tick();
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", BUSY); end
      checks++; if (DAC_SAT !== 2'b10) begin failures++; $display("FAIL rst_pre_sat got=%b exp=10", DAC_SAT); end
      #2;
      RST = 1'b1;
      #1;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", BUSY); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", DONE); end
      checks++; if (ADC_16Q48_OUT !== 128'h0) begin failures++; $display("FAIL rst_mid_adc got=%h exp=0", ADC_16Q48_OUT); end
      checks++; if (DAC_CODE_OUT !== 28'h0) begin failures++; $display("FAIL rst_mid_code got=%h exp=0", DAC_CODE_OUT); end
      checks++; if (DAC_SAT !== 2'b00) begin failures++; $display("FAIL rst_mid_sat got=%b exp=00", DAC_SAT); end
      DAC_VOLT_IN = '0;
      @(posedge ADC_CLK);
      #3;
      RST = 1'b0;
      seen_done = 1'b0;
      repeat (25) begin tick(); if (DONE === 1'b1 || BUSY === 1'b1) seen_done = 1'b1; end
      checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL rst_no_done got=%b exp=0", seen_done); end
      checks++; if (ADC_16Q48_OUT !== 128'h0) begin failures++; $display("FAIL rst_post_adc got=%h exp=0", ADC_16Q48_OUT); end
   endtask

   initial begin
      test_reset();
      test_avg_const();
      test_loopback();
      test_dac_volt();
      test_start_clear_alt();
      test_back_to_back();
      test_abort();
      test_reset_mid_acq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
